// File: rtl/triangle_sequencer_if.sv
// Triangle transfer channel from the sequencer to the rasterizer.
// The bundle carries three vertices per axis, plus index, last flag and a valid/ready handshake.
interface triangle_sequencer_if #(
  parameter int COORD_W = 32
);
  logic [3*COORD_W-1:0] TRI_X;
  logic [3*COORD_W-1:0] TRI_Y;
  logic [3*COORD_W-1:0] TRI_Z;
  logic [3:0]           TRI_IDX;
  logic                 TRI_LAST;
  logic                 TRI_VALID;
  logic                 TRI_READY;

  modport master (
    output TRI_X, TRI_Y, TRI_Z, TRI_IDX, TRI_LAST, TRI_VALID,
    input  TRI_READY
  );

  modport slave (
    input  TRI_X, TRI_Y, TRI_Z, TRI_IDX, TRI_LAST, TRI_VALID,
    output TRI_READY
  );
endinterface

// File: rtl/triangle_sequencer.sv
// Walks triangles 0..N-1 of the flat X/Y/Z vertex buffers on a software start edge.
// It emits one triangle per valid/ready transfer and reports BUSY, a DONE pulse and a frame count.
module triangle_sequencer #(
  parameter int MAX_TRIS = 12,
  parameter int COORD_W  = 32
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic [3*MAX_TRIS*COORD_W-1:0] X_IN,
  input  logic [3*MAX_TRIS*COORD_W-1:0] Y_IN,
  input  logic [3*MAX_TRIS*COORD_W-1:0] Z_IN,
  input  logic [COORD_W-1:0]            START_IN,
  input  logic [COORD_W-1:0]            SIZE_IN,
  triangle_sequencer_if.master          tri_if,
  output logic                          BUSY,
  output logic                          DONE,
  output logic                          SIZE_CLAMP,
  output logic [15:0]                   FRAME_COUNT
);
  localparam int NW = 3 * MAX_TRIS;
  localparam int W  = NW * COORD_W;
  localparam int AW = $clog2(NW);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, FIN} state_t;

  state_t             state;
  state_t             state_nx;
  logic               start_d;
  logic               start_edge;
  logic               size_over;
  logic               size_zero;
  logic [3:0]         idx;
  logic [3:0]         n;
  logic [3:0]         n_start;
  logic [AW-1:0]      base;
  logic [COORD_W-1:0] x_word [NW];
  logic [COORD_W-1:0] y_word [NW];
  logic [COORD_W-1:0] z_word [NW];
  logic               start_unused;

  // Word 0 sits at the MSBs of each flat buffer.
  for (genvar k = 0; k < NW; k++) begin : g_unpack
    assign x_word[k] = X_IN[W-1-k*COORD_W -: COORD_W];
    assign y_word[k] = Y_IN[W-1-k*COORD_W -: COORD_W];
    assign z_word[k] = Z_IN[W-1-k*COORD_W -: COORD_W];
  end

  assign start_unused = ^START_IN[COORD_W-1:1];
  assign start_edge   = START_IN[0] & ~start_d;
  assign size_over    = (SIZE_IN > COORD_W'(MAX_TRIS));
  assign size_zero    = (SIZE_IN == '0);
  assign n_start      = size_over ? 4'(MAX_TRIS) : SIZE_IN[3:0];
  assign base         = AW'(int'(idx) * 3);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start_edge) state_nx = size_zero ? FIN : LOAD;
      LOAD: state_nx = EMIT;
      EMIT: if (tri_if.TRI_READY) state_nx = tri_if.TRI_LAST ? FIN : LOAD;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    tri_if.TRI_VALID = 1'b0;
    BUSY             = 1'b0;
    DONE             = 1'b0;
    case (state)
      LOAD: BUSY = 1'b1;
      EMIT: begin
        BUSY             = 1'b1;
        tri_if.TRI_VALID = 1'b1;
      end
      FIN: begin
        BUSY = 1'b1;
        DONE = 1'b1;
      end
      default: ;
    endcase
  end

  // Triangle data only changes in LOAD, so outputs hold while EMIT is stalled.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      start_d         <= 1'b0;
      n               <= '0;
      idx             <= '0;
      SIZE_CLAMP      <= 1'b0;
      FRAME_COUNT     <= '0;
      tri_if.TRI_X    <= '0;
      tri_if.TRI_Y    <= '0;
      tri_if.TRI_Z    <= '0;
      tri_if.TRI_IDX  <= '0;
      tri_if.TRI_LAST <= 1'b0;
    end else begin
      start_d <= START_IN[0];
      case (state)
        IDLE: begin
          if (start_edge) begin
            n          <= n_start;
            SIZE_CLAMP <= size_over;
            idx        <= '0;
          end
        end
        LOAD: begin
          tri_if.TRI_X    <= {x_word[base], x_word[base+AW'(1)], x_word[base+AW'(2)]};
          tri_if.TRI_Y    <= {y_word[base], y_word[base+AW'(1)], y_word[base+AW'(2)]};
          tri_if.TRI_Z    <= {z_word[base], z_word[base+AW'(1)], z_word[base+AW'(2)]};
          tri_if.TRI_IDX  <= idx;
          tri_if.TRI_LAST <= (idx == n - 4'd1);
        end
        EMIT: begin
          if (tri_if.TRI_READY && !tri_if.TRI_LAST) idx <= idx + 4'd1;
        end
        FIN: FRAME_COUNT <= FRAME_COUNT + 16'd1;
        default: ;
      endcase
    end
  end
endmodule
